// File: rtl/alu_pkg.sv
// Shared constants for the ALU request arbiter.
// Widths, ALU opcodes and the arbiter FSM encoding.
package alu_pkg;

  localparam int W   = 16;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] ADD  = 3'd0;
  localparam logic [OPW-1:0] SUB  = 3'd1;
  localparam logic [OPW-1:0] SHR  = 3'd2;
  localparam logic [OPW-1:0] SHL  = 3'd3;
  localparam logic [OPW-1:0] NAND = 3'd4;
  localparam logic [OPW-1:0] OR   = 3'd5;
  localparam logic [OPW-1:0] DIR  = 3'd6;
  localparam logic [OPW-1:0] SAR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin arbiter.
// ptr names the preferred requester; it flips to the other side on every grant.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // Pick the winner: preferred side on a tie, lone requester otherwise.
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b11): grant = ptr ? 2'b10 : 2'b01;
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      default:          grant = 2'b00;
    endcase
  end

  // After a grant, prefer whoever did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two requesters.
// Accept -> EXEC -> CAPT -> RESP, one operation in flight.
module alu_req_arbiter
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_zero,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_z
);

  state_t     state;
  state_t     state_nx;
  logic       owner;
  logic [1:0] arb_valid;
  logic [1:0] grant;
  logic       accept;
  logic       rsp_fire;
  logic       unused_z;

  // The ALU's own zero flag is never trusted; zero comes from rsp_data.
  assign unused_z = alu_z;

  // Requests are only visible to the arbiter while idle and out of reset.
  assign arb_valid = (state == IDLE && rst_n) ?
                     {req1_valid, req0_valid} : 2'b00;

  alu_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (arb_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign rsp_fire   = owner ? rsp1_valid && rsp1_ready
                            : rsp0_valid && rsp0_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state: fixed three-cycle walk, then wait for the owner.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = CAPT;
      CAPT:    state_nx = RESP;
      RESP:    if (rsp_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the winner's operation on the accept edge; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      owner  <= 1'b0;
    end else if (accept) begin
      alu_a  <= grant[1] ? req1_a  : req0_a;
      alu_b  <= grant[1] ? req1_b  : req0_b;
      alu_op <= grant[1] ? req1_op : req0_op;
      owner  <= grant[1];
    end
  end

  // Capture the ALU result one cycle after it registered it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else if (state == CAPT) begin
      rsp_data <= alu_out;
      rsp_zero <= (alu_out == '0);
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter with a behavioural registered ALU.
// Expected responses are queued on accept and popped on rsp_valid.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_valid = 1'b0;
  logic           req0_ready;
  logic [OPW-1:0] req0_op = '0;
  logic [W-1:0]   req0_a = '0;
  logic [W-1:0]   req0_b = '0;
  logic           req1_valid = 1'b0;
  logic           req1_ready;
  logic [OPW-1:0] req1_op = '0;
  logic [W-1:0]   req1_a = '0;
  logic [W-1:0]   req1_b = '0;
  logic           rsp0_valid;
  logic           rsp0_ready = 1'b0;
  logic           rsp1_valid;
  logic           rsp1_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic           rsp_zero;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_out = '0;
  logic           alu_z;

  typedef struct packed {
    logic         owner;
    logic [W-1:0] data;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_req_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_z      (alu_z)
  );

  function automatic logic [W-1:0] alu_f(
    input logic [OPW-1:0] op,
    input logic [W-1:0]   a,
    input logic [W-1:0]   b
  );
    case (op)
      ADD:     alu_f = a + b;
      SUB:     alu_f = a - b;
      SHR:     alu_f = a >> b[3:0];
      SHL:     alu_f = a << b[3:0];
      NAND:    alu_f = ~(a & b);
      OR:      alu_f = a | b;
      DIR:     alu_f = b;
      default: alu_f = $signed(a) >>> b[3:0];
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_op, alu_a, alu_b);

  // The arbiter must ignore this; it is driven misleadingly on purpose.
  assign alu_z = (alu_out != '0);

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    exp_t e;
    int   n = 0;
    logic who;
    while (!(rsp0_valid || rsp1_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL drain_timeout got=no rsp_valid exp=rsp_valid");
    end else if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_rsp got=rsp0 %b rsp1 %b exp=none",
               rsp0_valid, rsp1_valid);
    end else begin
      e = sb.pop_front();
      who = rsp1_valid;
      if ({rsp1_valid, rsp0_valid} !== (e.owner ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rsp_owner got=%b%b exp_owner=%0d",
                 rsp1_valid, rsp0_valid, e.owner);
      end
      tests++;
      if (rsp_data !== e.data) begin
        fails++;
        $display("FAIL rsp_data got=%h exp=%h", rsp_data, e.data);
      end
      tests++;
      if (rsp_zero !== e.zero) begin
        fails++;
        $display("FAIL rsp_zero got=%b exp=%b", rsp_zero, e.zero);
      end
      if (who) rsp1_ready = 1'b1;
      else     rsp0_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (who) rsp1_ready = 1'b0;
      else     rsp0_ready = 1'b0;
      tests++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        fails++;
        $display("FAIL rsp_release got=%b%b exp=00",
                 rsp1_valid, rsp0_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req0_op = ADD;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({alu_a, alu_b, alu_op, rsp_data, rsp_zero} !== '0) begin
      fails++;
      $display("FAIL reset_regs got=%h %h %h %h %b exp=0",
               alu_a, alu_b, alu_op, rsp_data, rsp_zero);
    end
    tests++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin
      fails++;
      $display("FAIL reset_hs got=%b%b%b%b exp=0000",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid);
    end
    req0_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    req0_valid = 1'b1;
    req0_op = ADD;
    req0_a = 16'd54;
    req0_b = 16'd5;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL add_ready got=%b%b exp=01", req1_ready, req0_ready);
    end
    sb.push_back('{1'b0, 16'd59, 1'b0});
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_exec got=rdy %b vld %b exp=0 0",
               req0_ready, rsp0_valid);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (rsp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_capt got=%b exp=0", rsp0_valid);
    end
    @(negedge clk);
    tests++;
    if (rsp0_valid !== 1'b1) begin
      fails++;
      $display("FAIL add_latency got=%b exp=1", rsp0_valid);
    end
    drain();
  endtask

  task automatic test_sub_zero();
    rsp0_ready = 1'b1;
    req1_valid = 1'b1;
    req1_op = SUB;
    req1_a = 16'd5;
    req1_b = 16'd5;
    #1;
    tests++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      fails++;
      $display("FAIL sub_ready got=%b%b exp=10", req1_ready, req0_ready);
    end
    sb.push_back('{1'b1, 16'd0, 1'b1});
    @(negedge clk);
    req1_valid = 1'b0;
    drain();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_both_valid();
    do_reset();
    req0_valid = 1'b1;
    req0_op = ADD;
    req0_a = 16'd1;
    req0_b = 16'd1;
    req1_valid = 1'b1;
    req1_op = SHL;
    req1_a = 16'd1;
    req1_b = 16'd4;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL both_first got=%b%b exp=01", req1_ready, req0_ready);
    end
    sb.push_back('{1'b0, 16'd2, 1'b0});
    @(negedge clk);
    req0_valid = 1'b0;
    drain();
    #1;
    tests++;
    if (req1_ready !== 1'b1) begin
      fails++;
      $display("FAIL both_second got=%b exp=1", req1_ready);
    end
    sb.push_back('{1'b1, 16'd16, 1'b0});
    @(negedge clk);
    req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_alternate();
    logic [W-1:0] ex [4];
    ex[0] = 16'd30;
    ex[1] = 16'hFF00;
    ex[2] = 16'h0001;
    ex[3] = 16'hFFFF;
    do_reset();
    req0_valid = 1'b1;
    req0_op = ADD;
    req0_a = 16'd10;
    req0_b = 16'd20;
    req1_valid = 1'b1;
    req1_op = NAND;
    req1_a = 16'hFFFF;
    req1_b = 16'h00FF;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if ({req1_ready, req0_ready} !== ((k % 2) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL alt_grant_%0d got=%b%b exp_owner=%0d",
                 k, req1_ready, req0_ready, k % 2);
      end
      sb.push_back('{logic'(k % 2), ex[k], 1'b0});
      @(negedge clk);
      if (k == 0) begin
        req0_op = SHR;
        req0_a = 16'h8000;
        req0_b = 16'd15;
      end else if (k == 1) begin
        req1_op = SAR;
        req1_a = 16'h8000;
        req1_b = 16'd15;
      end else if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    req0_valid = 1'b1;
    req0_op = OR;
    req0_a = 16'h1234;
    req0_b = 16'h0001;
    @(negedge clk);
    req1_valid = 1'b1;
    while (!rsp0_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (rsp0_valid !== 1'b1 || rsp_data !== 16'h1235 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d got=vld %b data %h rdy %b%b exp=1 1235 00",
                 i, rsp0_valid, rsp_data, req1_ready, req0_ready);
      end
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    tests++;
    if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release got=vld %b rdy1 %b exp=0 1",
               rsp0_valid, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1;
    req0_op = ADD;
    req0_a = 16'd3;
    req0_b = 16'd4;
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({alu_a, alu_b, alu_op, rsp_data, rsp_zero,
         req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== '0) begin
      fails++;
      $display("FAIL mid_reset got=%h %h %h %h %b exp=0",
               alu_a, alu_b, alu_op, rsp_data, rsp_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_ghost_%0d got=%b%b exp=00",
                 i, rsp1_valid, rsp0_valid);
      end
    end
    req0_valid = 1'b1;
    req0_op = OR;
    req0_a = 16'h00F0;
    req0_b = 16'h000F;
    req1_valid = 1'b1;
    req1_op = SUB;
    req1_a = 16'd7;
    req1_b = 16'd2;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_ptr got=%b%b exp=01", req1_ready, req0_ready);
    end
    sb.push_back('{1'b0, 16'h00FF, 1'b0});
    @(negedge clk);
    req0_valid = 1'b0;
    drain();
    sb.push_back('{1'b1, 16'd5, 1'b0});
    @(negedge clk);
    req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_both_valid();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
